bus_arb2: RTL and testbench

Two-requester arbiter and sequencer for a shared 8-bit data path built on a 2:1 byte mux, for example core vs. DMA/IO agent. It grants exactly one requester at a time and drives the mux select. It registers the selected byte with a valid strobe. Fairness is round-robin on contention, and a hold limit preempts a requester that keeps the bus while the other waits.

---
 rtl/bus_arb2_pkg.sv | 13 +
 rtl/bus_arb2_mux8b.sv | 13 +
 rtl/bus_arb2.sv | 102 ++++++++++
 tb/tb_bus_arb2.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bus_arb2_pkg.sv
// Shared encodings for the two-requester bus arbiter.
package bus_arb2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNTA = 2'b01,
    ST_GNTB = 2'b10
  } arbState_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/bus_arb2_mux8b.sv
// 8-bit 2:1 byte mux feeding the shared data path.
module mux8b
  import bus_arb2_pkg::*;
(
  input  logic       sel,
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  output logic [7:0] muxOut
);

  assign muxOut = (sel == SEL_A) ? inA : inB;

endmodule

// File: rtl/bus_arb2.sv
// Round-robin arbiter for two requesters sharing one byte path, with hold-limit
// preemption under contention and a registered capture of the selected byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; both grants low; sel keeps its last value
// ST_GNTA | requester A owns the bus, sel=A
// ST_GNTB | requester B owns the bus, sel=B
module bus_arb2
  import bus_arb2_pkg::*;
#(
  parameter int MAXHOLD = 4,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqA,
  input  logic       reqB,
  input  logic [7:0] datA,
  input  logic [7:0] datB,
  output logic       gntA,
  output logic       gntB,
  output logic       sel,
  output logic [7:0] datC,
  output logic       valid
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAXHOLD);

  arbState_t     state;
  arbState_t     stateNxt;
  logic          lastSel;
  logic [CW-1:0] cnt;
  logic [7:0]    muxOut;
  logic          holdDone;
  logic          capture;

  mux8b uMux (
    .sel   (sel),
    .inA   (datA),
    .inB   (datB),
    .muxOut(muxOut)
  );

  // >= rather than == so an owner whose count already saturated while
  // uncontested is still released once the other side starts asking.
  assign holdDone = (cnt >= HOLD_LAST);
  assign capture  = ((state == ST_GNTA) && reqA) || ((state == ST_GNTB) && reqB);

  always_comb begin
    stateNxt = state;
    case (state)
      ST_IDLE: begin
        if (reqA && reqB) begin
          stateNxt = (lastSel == SEL_B) ? ST_GNTA : ST_GNTB;
        end else if (reqA) begin
          stateNxt = ST_GNTA;
        end else if (reqB) begin
          stateNxt = ST_GNTB;
        end
      end
      ST_GNTA: begin
        if (!reqA || (reqB && holdDone)) stateNxt = ST_IDLE;
      end
      ST_GNTB: begin
        if (!reqB || (reqA && holdDone)) stateNxt = ST_IDLE;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= SEL_A;
      lastSel <= SEL_B;
      cnt     <= '0;
      datC    <= 8'h00;
      valid   <= 1'b0;
    end else begin
      state <= stateNxt;
      if ((state == ST_IDLE) && (stateNxt == ST_GNTA)) begin
        sel     <= SEL_A;
        lastSel <= SEL_A;
        cnt     <= '0;
      end else if ((state == ST_IDLE) && (stateNxt == ST_GNTB)) begin
        sel     <= SEL_B;
        lastSel <= SEL_B;
        cnt     <= '0;
      end else if ((state != ST_IDLE) && (cnt != HOLD_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      valid <= capture;
      if (capture) datC <= muxOut;
    end
  end

  assign gntA = (state == ST_GNTA);
  assign gntB = (state == ST_GNTB);

endmodule

// File: tb/tb_bus_arb2.sv
// Directed self-checking bench for bus_arb2 with MAXHOLD=4.
module tb_bus_arb2;

  logic       clk;
  logic       rst;
  logic       reqA;
  logic       reqB;
  logic [7:0] datA;
  logic [7:0] datB;
  logic       gntA;
  logic       gntB;
  logic       sel;
  logic [7:0] datC;
  logic       valid;

  int nChecks = 0;
  int nFail   = 0;

  bus_arb2 #(.MAXHOLD(4), .CW(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .reqA (reqA),
    .reqB (reqB),
    .datA (datA),
    .datB (datB),
    .gntA (gntA),
    .gntB (gntB),
    .sel  (sel),
    .datC (datC),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; grants must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("mutex", {7'd0, gntA & gntB}, 8'h00);
  endtask

  initial begin
    rst  = 1'b1;
    reqA = 1'b1;
    reqB = 1'b1;
    datA = 8'h00;
    datB = 8'h00;

    // Reset held two cycles with both requesting.
    tick();
    tick();
    chk("rst_gntA", {7'd0, gntA}, 8'h00);
    chk("rst_gntB", {7'd0, gntB}, 8'h00);
    chk("rst_sel", {7'd0, sel}, 8'h00);
    chk("rst_datC", datC, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'h00);

    // First contention after reset goes to A; B keeps asking -> preemption.
    rst  = 1'b0;
    datA = 8'h11;
    datB = 8'h22;
    tick();
    chk("first_gntA", {7'd0, gntA}, 8'h01);
    chk("first_sel", {7'd0, sel}, 8'h00);
    chk("first_valid", {7'd0, valid}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("holdA_gnt", {7'd0, gntA}, 8'h01);
      chk("holdA_valid", {7'd0, valid}, 8'h01);
      chk("holdA_datC", datC, 8'h11);
    end
    tick();
    chk("preA_gntA", {7'd0, gntA}, 8'h00);
    chk("preA_gntB", {7'd0, gntB}, 8'h00);
    chk("preA_valid", {7'd0, valid}, 8'h01);
    tick();
    chk("toB_gntB", {7'd0, gntB}, 8'h01);
    chk("toB_sel", {7'd0, sel}, 8'h01);
    chk("toB_valid", {7'd0, valid}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("holdB_gnt", {7'd0, gntB}, 8'h01);
      chk("holdB_datC", datC, 8'h22);
    end
    tick();
    chk("preB_gntB", {7'd0, gntB}, 8'h00);
    chk("preB_gntA", {7'd0, gntA}, 8'h00);
    chk("preB_selhold", {7'd0, sel}, 8'h01);
    tick();
    chk("backA_gntA", {7'd0, gntA}, 8'h01);
    chk("backA_sel", {7'd0, sel}, 8'h00);

    reqA = 1'b0;
    reqB = 1'b0;
    tick();
    chk("release_gntA", {7'd0, gntA}, 8'h00);
    chk("release_valid", {7'd0, valid}, 8'h00);

    // Single requester B.
    datB = 8'h5A;
    reqB = 1'b1;
    tick();
    chk("single_gntB", {7'd0, gntB}, 8'h01);
    chk("single_sel", {7'd0, sel}, 8'h01);
    chk("single_valid0", {7'd0, valid}, 8'h00);
    tick();
    chk("single_valid1", {7'd0, valid}, 8'h01);
    chk("single_datC1", datC, 8'h5A);
    tick();
    chk("single_valid2", {7'd0, valid}, 8'h01);
    chk("single_datC2", datC, 8'h5A);
    reqB = 1'b0;
    tick();
    chk("single_drop_gntB", {7'd0, gntB}, 8'h00);
    chk("single_drop_valid", {7'd0, valid}, 8'h00);
    chk("single_drop_datC", datC, 8'h5A);

    // Contention with B as last owner -> A.
    reqA = 1'b1;
    reqB = 1'b1;
    tick();
    chk("rr_gntA", {7'd0, gntA}, 8'h01);
    chk("rr_gntB", {7'd0, gntB}, 8'h00);
    reqA = 1'b0;
    reqB = 1'b0;
    tick();
    chk("rr_idle", {7'd0, gntA}, 8'h00);

    // Uncontested hold with a data ramp.
    reqA = 1'b1;
    datA = 8'h00;
    tick();
    chk("unc_gntA", {7'd0, gntA}, 8'h01);
    for (int i = 0; i < 20; i++) begin
      datA = 8'(i);
      tick();
      chk("unc_hold", {7'd0, gntA}, 8'h01);
      chk("unc_valid", {7'd0, valid}, 8'h01);
      chk("unc_datC", datC, 8'(i));
    end
    reqA = 1'b0;
    tick();
    chk("unc_release", {7'd0, gntA}, 8'h00);

    // Reset in the middle of a B grant.
    datB = 8'hFF;
    reqB = 1'b1;
    tick();
    chk("mid_gntB", {7'd0, gntB}, 8'h01);
    tick();
    chk("mid_datC", datC, 8'hFF);
    rst  = 1'b1;
    reqA = 1'b1;
    tick();
    chk("mid_rst_gntB", {7'd0, gntB}, 8'h00);
    chk("mid_rst_sel", {7'd0, sel}, 8'h00);
    chk("mid_rst_valid", {7'd0, valid}, 8'h00);
    chk("mid_rst_datC", datC, 8'h00);
    rst = 1'b0;
    tick();
    chk("mid_rst_lastA", {7'd0, gntA}, 8'h01);
    chk("mid_rst_lastB", {7'd0, gntB}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
